// File: rtl/mips_dcache_if.sv
// Memory-side channel of the data cache: valid/ready request, valid-only refill response.
interface mips_dcache_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rnw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mips_dcache.sv
// Blocking direct-mapped write-through, no-write-allocate data cache for the MIPS150 data port.
// Load hits return in the lookup cycle; misses refill a whole line, stores always go to memory.
module mips_dcache #(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    mips_dcache_if.master mem
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned WI_W  = OFF_W + IDX_W;
    localparam int unsigned TAG_W = 30 - WI_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, MISS_REQ, REFILL, WRITE_REQ, DONE} state_t;

    state_t state, next_state;

    logic [31:0]      data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    logic        pending;
    logic        req_store;
    logic [31:2] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic [31:0] rd_word;
    logic [31:0] dout_hold;
    logic [31:0] refill_word;
    logic [OFF_W-1:0] beat;

    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic [TAG_W-1:0] req_tag;
    logic hit, lookup, capture, beat_in, last_beat;
    logic unused_addr_bits;

    assign req_idx   = req_addr[WI_W+1:OFF_W+2];
    assign req_off   = req_addr[OFF_W+1:2];
    assign req_tag   = req_addr[31:WI_W+2];
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lookup    = (state == IDLE) && pending;
    assign capture   = !stall && (dcache_re || (dcache_we != 4'b0000));
    assign beat_in   = (state == REFILL) && mem.mem_resp_valid;
    assign last_beat = beat_in && (beat == LAST_BEAT);
    assign unused_addr_bits = ^dcache_addr[1:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (lookup) begin
                           if (req_store)  next_state = WRITE_REQ;
                           else if (!hit)  next_state = MISS_REQ;
                       end
            MISS_REQ:  if (mem.mem_req_ready) next_state = REFILL;
            REFILL:    if (last_beat)         next_state = DONE;
            WRITE_REQ: if (mem.mem_req_ready) next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Outputs: stall rises combinationally in the lookup cycle of a miss or store
    always_comb begin
        stall             = 1'b0;
        dcache_dout       = dout_hold;
        mem.mem_req_valid = 1'b0;
        mem.mem_req_rnw   = 1'b1;
        mem.mem_req_addr  = 32'h0;
        mem.mem_req_data  = 32'h0;
        mem.mem_req_mask  = 4'h0;
        case (state)
            IDLE: if (lookup) begin
                if (req_store || !hit) stall = 1'b1;
                else                   dcache_dout = rd_word;
            end
            MISS_REQ: begin
                stall             = 1'b1;
                mem.mem_req_valid = 1'b1;
                mem.mem_req_addr  = {req_addr, 2'b00} & ~32'(LINE_WORDS*4 - 1);
            end
            REFILL: stall = 1'b1;
            WRITE_REQ: begin
                stall             = 1'b1;
                mem.mem_req_valid = 1'b1;
                mem.mem_req_rnw   = 1'b0;
                mem.mem_req_addr  = {req_addr, 2'b00};
                mem.mem_req_data  = req_data;
                mem.mem_req_mask  = req_mask;
            end
            default: ;
        endcase
    end

    // Request capture, refill bookkeeping and load-data holding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= 1'b0;
            req_store   <= 1'b0;
            req_addr    <= '0;
            req_data    <= 32'h0;
            req_mask    <= 4'h0;
            rd_word     <= 32'h0;
            dout_hold   <= 32'h0;
            refill_word <= 32'h0;
            beat        <= '0;
            valid       <= '0;
        end else begin
            pending <= capture;
            if (capture) begin
                req_store <= (dcache_we != 4'b0000);
                req_addr  <= dcache_addr[31:2];
                req_data  <= dcache_din;
                req_mask  <= dcache_we;
                rd_word   <= data_mem[dcache_addr[WI_W+1:2]];
            end
            if (lookup && !req_store) begin
                if (hit) dout_hold <= rd_word;
                else     valid[req_idx] <= 1'b0;
            end
            beat <= (state == REFILL) ? (beat + OFF_W'(beat_in)) : '0;
            if (beat_in && (beat == req_off)) refill_word <= mem.mem_resp_data;
            if (last_beat) begin
                valid[req_idx] <= 1'b1;
                dout_hold      <= (req_off == LAST_BEAT) ? mem.mem_resp_data : refill_word;
            end
        end
    end

    // Data and tag arrays carry no reset; the valid bits guard them
    always_ff @(posedge clk) begin
        if (beat_in) data_mem[{req_idx, beat}] <= mem.mem_resp_data;
        if (last_beat) tag_mem[req_idx] <= req_tag;
        if (lookup && req_store && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (req_mask[b]) data_mem[req_addr[WI_W+1:2]][8*b +: 8] <= req_data[8*b +: 8];
            end
        end
    end
endmodule

// File: doc/mips_dcache.md
Name: mips_dcache

Overview:
- Blocking, direct-mapped, write-through, no-write-allocate data cache sitting directly downstream of the MIPS150 core's data port.
- Consumes dcache_addr/dcache_we/dcache_re/dcache_din from the core; returns dcache_dout and drives the core's stall input.
- On misses and stores it talks to the memory arbiter over a valid/ready request channel and a valid-only response channel.

Parameters:
- NUM_LINES, 64, number of cache lines; power of two.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- dcache_addr  in  32  byte address from the core; bits [1:0] ignored.
- dcache_re  in  1  load request.
- dcache_we  in  4  per-byte store enables; non-zero means store.
- dcache_din  in  32  store data, byte lanes aligned to dcache_we.
- dcache_dout  out  32  load data.
- stall  out  1  freezes the core pipeline.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  arbiter accepts the request.
- mem_req_rnw  out  1  1 = line read, 0 = word write.
- mem_req_addr  out  32  read: line-aligned address; write: word address.
- mem_req_data  out  32  write data.
- mem_req_mask  out  4  write byte mask.
- mem_resp_valid  in  1  one refill word per asserted cycle, word 0 first.
- mem_resp_data  in  32  refill word.

Behaviour:
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:2].
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- Storage: data array, tag array, and one valid bit per line.
- Reset (asynchronous, rst=0):
  - All valid bits cleared; state IDLE.
  - stall=0, mem_req_valid=0, mem_req_rnw=1, mem_req_addr/data/mask=0, dcache_dout=0.
- Request capture:
  - A request is captured at a rising edge when stall=0 and (dcache_re=1 or dcache_we!=0).
  - If both are set, the request is treated as a store.
  - Captured address, data and mask are held in registers. The core keeps its inputs stable while stall=1.
- IDLE / LOOKUP, evaluated the cycle after capture:
  - Read hit: dcache_dout = the addressed word, registered, valid this cycle; stall=0. Load-hit latency is 1 cycle, zero stall cycles.
  - Read miss: stall goes high combinationally in this cycle; go to MISS_REQ.
  - Store, hit or miss: stall high; go to WRITE_REQ.
  - On a store hit, the masked bytes are written into the data array at this same edge.
  - A store miss does not allocate.
- MISS_REQ:
  - Drive mem_req_valid=1, rnw=1, addr = {tag,index,0}.
  - Hold until mem_req_ready=1, then go to REFILL.
- REFILL:
  - Each mem_resp_valid writes mem_resp_data into word counter k of the line; k counts from 0.
  - When k reaches LINE_WORDS-1: write the tag, set the valid bit, latch the requested word into dcache_dout, go to DONE.
  - Response gaps are allowed.
- WRITE_REQ:
  - Drive mem_req_valid=1, rnw=0, word address, data, mask.
  - Hold all fields stable until mem_req_ready=1, then go to DONE.
- DONE:
  - stall=0 for one cycle; return to IDLE.
  - dcache_dout holds the load value until the next load completes.
- stall:
  - Asserted from the lookup cycle of a miss or store through the last cycle of REFILL or WRITE_REQ.
  - Deasserted in DONE.
- External stall: mem_resp_valid outside REFILL is ignored, including stray beats after a reset.
- Reset mid-operation:
  - Refill aborts; the partially filled line stays invalid.
  - mem_req_valid drops immediately.
- A miss replaces the resident line unconditionally. Write-through means no writeback is ever needed.
- Index wrap: addresses that differ only in tag alias to the same line and evict each other.

Test Plan:
- Reset, then load 0x00000010 → miss; one read request at 0x00000010. Return beats 0xA0,0xA1,0xA2,0xA3 → dout=0xA0; stall high from the lookup cycle until DONE.
- Load 0x0000001C right after the previous refill → hit; dout=0xA3 one cycle after capture; stall stays 0.
- Store we=4'b0011, din=0x1234BEEF to 0x00000014 (a hit) → write request mask=0011, data=0x1234BEEF. A later load of 0x14 returns 0x0000BEEF merged with 0xA1's upper bytes, i.e. 0x000000A1→0x0000BEEF.
- Store to uncached 0x00004000 → write request issued; a following load of 0x4000 misses (no allocate).
- Hold mem_req_ready=0 for 5 cycles → request fields stay stable and stall=1 throughout. Insert 2-cycle gaps between refill beats → line completes correctly.
- Pull rst low after 2 refill beats, release, load the same address → a fresh miss is issued and the old stray beats are ignored.
